// File: rtl/kronos_types.sv
// -----------------------------------------------------------------------------
// kronos_types
// Shared Kronos type definitions. This slice adds the captured data-bus
// request record and the state encoding of the data-memory responder, plus a
// small helper that forms the unsigned 33-bit offset of an address from a base.
// Ports: none (package).
// Related build macro: KRONOS_DMEM_RANGE_CHECK_EN (consumed by
// kronos_dmem_responder).
// -----------------------------------------------------------------------------
package kronos_types;

  // Request as captured by the data-memory responder in IDLE.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        wr_en;
  } dbus_req_t;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_e;

  // Bit 32 of the result is the borrow: set when addr lies below base.
  function automatic logic [32:0] dmem_offset(input logic [31:0] addr,
                                              input logic [31:0] base);
    dmem_offset = {1'b0, addr} - {1'b0, base};
  endfunction

endpackage

// File: rtl/kronos_spsram.sv
// -----------------------------------------------------------------------------
// kronos_spsram
// Single-port synchronous RAM, 32-bit words, per-byte write enables and a
// registered read port. The read register only changes on a read access, so
// it holds the last loaded word across stores and idle cycles.
// Ports:
//   clk      - clock
//   rstz     - async active-low reset (clears the read register only)
//   i_en     - access enable
//   i_we     - 1 = write, 0 = read
//   i_be     - byte enables for writes
//   i_addr   - word index
//   i_wdata  - write data
//   o_rdata  - registered read data
// -----------------------------------------------------------------------------
module kronos_spsram #(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstz,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  // Byte-lane writes; the array itself is never reset
  always_ff @(posedge clk) begin
    if (i_en && i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) begin
          r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  // Registered read port, updated only by read accesses
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      r_rdata <= 32'h0000_0000;
    end else if (i_en && !i_we) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/kronos_dmem_responder.sv
// -----------------------------------------------------------------------------
// kronos_dmem_responder
// Memory-side end of the Kronos load/store handshake. Captures a request in
// IDLE, waits WAIT_CYCLES, then performs the RAM access on the edge entering
// RESP and pulses data_ack for one cycle. All outputs come from registers.
// Build macro: KRONOS_DMEM_RANGE_CHECK_EN
//   defined   - out-of-range accesses give data_err, no write, zero load data
//   undefined - no comparator; index = addr[$clog2(DEPTH)+1:2] (aliasing)
// Ports:
//   clk, rstz     - clock, async active-low reset
//   data_addr     - byte address (bits [1:0] ignored)
//   data_wr_data  - lane-aligned store data
//   data_mask     - byte enables for stores
//   data_wr_en    - 1 = store, 0 = load
//   data_req      - request valid
//   data_ack      - one-cycle completion pulse
//   data_err      - access fault, qualified by data_ack
//   data_rd_data  - load word, held until the next acknowledge
// -----------------------------------------------------------------------------
module kronos_dmem_responder
  import kronos_types::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr_data,
  input  logic [3:0]  data_mask,
  input  logic        data_wr_en,
  input  logic        data_req,
  output logic        data_ack,
  output logic        data_err,
  output logic [31:0] data_rd_data
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  dmem_state_e r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  dbus_req_t   r_req, w_req_live, w_acc;
  logic        r_ack, r_err, r_rd_zero;
  logic        w_fault, w_enter_resp, w_ram_en;
  logic [AW-1:0] w_idx;
  logic [31:0] w_ram_q;

  assign w_req_live = '{addr: data_addr, wdata: data_wr_data,
                        mask: data_mask, wr_en: data_wr_en};

  // With zero wait states the RESP entry edge is also the capture edge, so the
  // access must use the live request; otherwise the captured copy is used.
  assign w_acc = (r_state == DMEM_IDLE) ? w_req_live : r_req;

`ifdef KRONOS_DMEM_RANGE_CHECK_EN
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;
  logic [32:0] w_off;

  // Offset is 33 bits wide so neither a borrow nor base+span can wrap.
  assign w_off   = dmem_offset(w_acc.addr, BASE_ADDR);
  assign w_fault = w_off[32] || (w_off >= SPAN);
  assign w_idx   = w_off[AW+1:2];
`else
  logic w_unused_addr;

  assign w_fault       = 1'b0;
  assign w_idx         = w_acc.addr[AW+1:2];
  assign w_unused_addr = ^{w_acc.addr[31:AW+2], w_acc.addr[1:0], BASE_ADDR};
`endif

  // Next-state and wait-counter logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      DMEM_IDLE: begin
        if (data_req) begin
          if (WAIT_LOAD == 4'd0) begin
            w_state_nxt = DMEM_RESP;
          end else begin
            w_state_nxt = DMEM_WAIT;
            w_cnt_nxt   = WAIT_LOAD;
          end
        end else begin
          w_state_nxt = DMEM_IDLE;
        end
      end
      DMEM_WAIT: begin
        if (r_cnt <= 4'd1) begin
          w_state_nxt = DMEM_RESP;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt   = r_cnt - 4'd1;
        end
      end
      DMEM_RESP: begin
        w_state_nxt = DMEM_IDLE;
      end
      default: begin
        w_state_nxt = DMEM_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign w_enter_resp = (w_state_nxt == DMEM_RESP);
  assign w_ram_en     = w_enter_resp && !w_fault;

  // State, captured request and response flags
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      r_state   <= DMEM_IDLE;
      r_cnt     <= 4'd0;
      r_req     <= '0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_rd_zero <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (r_state == DMEM_IDLE && data_req) begin
        r_req <= w_req_live;
      end
      r_ack <= w_enter_resp;
      r_err <= w_enter_resp && w_fault;
      // A faulting load forces zero read data; stores leave it untouched.
      if (w_enter_resp && !w_acc.wr_en) begin
        r_rd_zero <= w_fault;
      end
    end
  end

  kronos_spsram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .rstz    (rstz),
    .i_en    (w_ram_en),
    .i_we    (w_acc.wr_en),
    .i_be    (w_acc.mask),
    .i_addr  (w_idx),
    .i_wdata (w_acc.wdata),
    .o_rdata (w_ram_q)
  );

  assign data_ack     = r_ack;
  assign data_err     = r_err;
  assign data_rd_data = r_rd_zero ? 32'h0000_0000 : w_ram_q;

endmodule

// File: tb/tb_kronos_dmem_responder.sv
// Bench: two responders (0 and 3 wait states) share one stimulus stream.
// Expected responses come from an array-based memory model and are queued per
// instance; a monitor per instance pops and checks on every acknowledge.
module tb_kronos_dmem_responder;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rstz;
  logic [31:0] data_addr, data_wr_data;
  logic [3:0]  data_mask;
  logic        data_wr_en, data_req;
  logic        ack0, err0, ack3, err3;
  logic [31:0] rd0, rd3;

  kronos_dmem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rstz(rstz), .data_addr(data_addr), .data_wr_data(data_wr_data),
    .data_mask(data_mask), .data_wr_en(data_wr_en), .data_req(data_req),
    .data_ack(ack0), .data_err(err0), .data_rd_data(rd0));

  kronos_dmem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rstz(rstz), .data_addr(data_addr), .data_wr_data(data_wr_data),
    .data_mask(data_mask), .data_wr_en(data_wr_en), .data_req(data_req),
    .data_ack(ack3), .data_err(err3), .data_rd_data(rd3));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [31:0] rd;
    int          cyc;
  } exp_t;

  exp_t        q0[$];
  exp_t        q3[$];
  logic [31:0] mdl [2][DEPTH];
  logic [31:0] last_rd [2];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: compute one instance's response and update its memory image.
  task automatic push_one(input int k, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] m, input int t);
    exp_t   e;
    bit     err;
    int     idx;
    longint la;
    la = longint'(a);
`ifdef KRONOS_DMEM_RANGE_CHECK_EN
    err = !((la >= longint'(BASE)) && (la < longint'(BASE) + 4 * DEPTH));
    idx = err ? 0 : int'((la - longint'(BASE)) / 4);
`else
    err = 1'b0;
    idx = int'((la / 4) % DEPTH);
`endif
    if (wr) begin
      if (!err) begin
        for (int b = 0; b < 4; b++)
          if (m[b]) mdl[k][idx][8*b +: 8] = wd[8*b +: 8];
      end
      e.rd = last_rd[k];
    end else begin
      e.rd = err ? 32'h0 : mdl[k][idx];
      last_rd[k] = e.rd;
    end
    e.err = err;
    e.cyc = t + ((k == 0) ? 0 : 3);
    if (k == 0) q0.push_back(e);
    else        q3.push_back(e);
  endtask

  task automatic scramble();
    data_addr    = $urandom;
    data_wr_data = $urandom;
    data_mask    = 4'($urandom);
    data_wr_en   = 1'($urandom);
  endtask

  task automatic drive(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] m);
    data_wr_en   = wr;
    data_addr    = a;
    data_wr_data = wd;
    data_mask    = m;
    data_req     = 1'b1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q3.size() != 0) && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (q0.size() != 0 || q3.size() != 0) begin
      total++;
      bad++;
      $display("FAIL ack_timeout: pending w0=%0d w3=%0d want 0", q0.size(), q3.size());
      q0.delete();
      q3.delete();
    end
  endtask

  // One transaction: inputs are garbled right after capture to show they are ignored.
  task automatic do_op(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] m);
    @(negedge clk);
    drive(wr, a, wd, m);
    @(posedge clk);
    #1;
    push_one(0, wr, a, wd, m, cyc);
    push_one(1, wr, a, wd, m, cyc);
    data_req = 1'b0;
    scramble();
    wait_drain();
  endtask

  task automatic check_reset_outputs();
    chk("rst_ack_w0", 32'(ack0), 32'h0);
    chk("rst_err_w0", 32'(err0), 32'h0);
    chk("rst_rd_w0",  rd0,       32'h0);
    chk("rst_ack_w3", 32'(ack3), 32'h0);
    chk("rst_err_w3", 32'(err3), 32'h0);
    chk("rst_rd_w3",  rd3,       32'h0);
  endtask

  // Monitor for the zero-wait instance
  always @(negedge clk) begin
    exp_t e;
    if (ack0 === 1'b1) begin
      if (q0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack_w0: got ack at cycle %0d want none", cyc);
      end else begin
        e = q0.pop_front();
        chk("ack_cycle_w0", 32'(cyc), 32'(e.cyc));
        chk("err_w0", 32'(err0), 32'(e.err));
        chk("rd_w0", rd0, e.rd);
      end
    end
  end

  // Monitor for the three-wait instance
  always @(negedge clk) begin
    exp_t e;
    if (ack3 === 1'b1) begin
      if (q3.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack_w3: got ack at cycle %0d want none", cyc);
      end else begin
        e = q3.pop_front();
        chk("ack_cycle_w3", 32'(cyc), 32'(e.cyc));
        chk("err_w3", 32'(err3), 32'(e.err));
        chk("rd_w3", rd3, e.rd);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] outa [4];
    logic [31:0] a;
    logic [3:0]  m;
    int          w;
    outa = '{32'h0000_1000, 32'h0000_1004, 32'h0000_1FFC, 32'hFFFF_FFFC};
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;

    // Reset with a request pending: outputs stay low.
    rstz = 1'b0;
    scramble();
    data_req = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    data_req = 1'b0;
    rstz = 1'b1;

    // Fill the words used by the random phase (0..15 and the last word).
    for (int i = 0; i < 16; i++) do_op(1'b1, 32'(i * 4), $urandom, 4'hF);
    do_op(1'b1, 32'h0000_0FFC, $urandom, 4'hF);

    // Word store then load.
    do_op(1'b1, BASE + 32'd8, 32'hDEAD_BEEF, 4'hF);
    do_op(1'b0, BASE + 32'd8, 32'h0, 4'h0);

    // Byte lanes and the empty-mask store.
    do_op(1'b1, 32'h0000_0010, 32'h1122_3344, 4'hF);
    do_op(1'b1, 32'h0000_0010, 32'hAA00_0000, 4'b1000);
    do_op(1'b0, 32'h0000_0010, 32'h0, 4'h0);
    do_op(1'b1, 32'h0000_0010, 32'h5566_7788, 4'b0000);
    do_op(1'b0, 32'h0000_0013, 32'h0, 4'hF);

    // Range boundaries.
    do_op(1'b1, 32'h0000_1000, 32'h5555_AAAA, 4'hF);
    do_op(1'b0, 32'h0000_0FFC, 32'h0, 4'h0);
    do_op(1'b0, 32'h0000_0000, 32'h0, 4'h0);
    do_op(1'b0, 32'h0000_1000, 32'h0, 4'h0);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) < 7) begin
        w = $urandom_range(0, 16);
        a = (w == 16) ? 32'h0000_0FFC : 32'(w * 4);
      end else begin
        a = outa[$urandom_range(0, 3)];
      end
      a = a + 32'($urandom_range(0, 3));
      m = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      do_op(1'($urandom), a, $urandom, m);
    end

    // Request held high: the zero-wait instance takes two loads (acks two
    // cycles apart), the three-wait instance only one.
    @(negedge clk);
    drive(1'b0, 32'h0000_0008, 32'h0, 4'hF);
    @(posedge clk);
    #1;
    push_one(0, 1'b0, 32'h0000_0008, 32'h0, 4'hF, cyc);
    push_one(1, 1'b0, 32'h0000_0008, 32'h0, 4'hF, cyc);
    @(posedge clk);
    @(posedge clk);
    #1;
    push_one(0, 1'b0, 32'h0000_0008, 32'h0, 4'hF, cyc);
    data_req = 1'b0;
    scramble();
    wait_drain();

    // Reset during the wait states of a store: only the zero-wait copy writes.
    @(negedge clk);
    drive(1'b1, 32'h0000_0014, 32'hC0FF_EE11, 4'hF);
    @(posedge clk);
    #1;
    push_one(0, 1'b1, 32'h0000_0014, 32'hC0FF_EE11, 4'hF, cyc);
    data_req = 1'b0;
    scramble();
    @(posedge clk);
    @(negedge clk);
    rstz = 1'b0;
    data_req = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    q3.delete();
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    data_req = 1'b0;
    rstz = 1'b1;
    do_op(1'b0, 32'h0000_0014, 32'h0, 4'h0);

    // A few more after the second reset.
    for (int n = 0; n < 20; n++) begin
      w = $urandom_range(0, 15);
      do_op(1'($urandom), 32'(w * 4), $urandom, 4'($urandom));
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kronos_dmem_responder.md
# kronos_dmem_responder

Data-bus responder for the Kronos core: the memory-side end of the load/store request/acknowledge handshake that the write-back stage initiates for `ld`/`st` operations. It owns a word-organised, byte-maskable local RAM and answers each request with a single-cycle acknowledge after a programmable number of wait states. Out-of-range accesses are flagged on an error line, which the core turns into LOAD_ACCESS_FAULT (5) or STORE_ACCESS_FAULT (7). It is used as the data memory in standalone core benches and small SoC builds.

## Interface
- `BASE_ADDR`, 32'h0000_0000 — byte address of word 0; must be 4-byte aligned.
- `DEPTH`, 1024 — RAM depth in 32-bit words; power of two, ≥ 4.
- `WAIT_CYCLES`, 0 — extra wait states before acknowledge, 0..15.
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`  in  1  — clock; all state changes on the rising edge.
  - `rstz`  in  1  — asynchronous, active-low reset.
- `data_addr`  in  32  — byte address; bits [1:0] are ignored.
- `data_wr_data`  in  32  — store data, already lane-aligned by the initiator.
- `data_mask`  in  4  — byte enables; bit i enables byte lane [8i+7:8i].
- `data_wr_en`  in  1  — 1 = store, 0 = load.
- `data_req`  in  1  — request valid.
- `data_ack`  out  1  — transaction complete; one-cycle pulse.
- `data_err`  out  1  — access fault; valid only while `data_ack` = 1.
- `data_rd_data`  out  32  — full load word; valid while `data_ack` = 1 and held until the next acknowledge.

## Operation
- FSM has three states: IDLE, WAIT and RESP.
  - IDLE + `data_req`: capture addr/wdata/mask/wr_en into the request register. If `WAIT_CYCLES` = 0, go to RESP. Otherwise load the wait counter with `WAIT_CYCLES` and go to WAIT.
  - WAIT: decrement the counter each cycle. At count 1, go to RESP.
  - RESP: drive `data_ack` = 1 for exactly one cycle, then go to IDLE.
- Memory access happens on the edge that enters RESP, using only the captured request. Input changes after capture are ignored.
  - Load: return the full word at index `(addr − BASE_ADDR) >> 2`. The mask is ignored; the initiator extracts bytes and halves.
  - Store: write the byte lanes whose mask bit is 1. Mask 4'b0000 is a legal no-op store. `data_rd_data` is left unchanged on stores.
- In range means `BASE_ADDR ≤ addr < BASE_ADDR + 4*DEPTH`, compared over the full 32 bits with no wrap. The last word (`BASE_ADDR + 4*DEPTH − 4`) is in range.
- On a fault (see Configuration):
  - `data_err` = 1 together with `data_ack`.
  - Nothing is written.
  - `data_rd_data` = 0.
- `data_req` dropping during WAIT (protocol violation): the transaction still completes and is acknowledged.
- `data_req` held high through the ack cycle: treated as a new request, captured in IDLE on the next cycle.
- Reset values: `data_ack` = 0, `data_err` = 0, `data_rd_data` = 0, FSM = IDLE, counter = 0. RAM contents are not reset.
- Reset asserted mid-transaction aborts it. An in-flight store that has not reached the RESP entry edge is not written.

## Timing
- Request first seen high in IDLE at edge t produces `data_ack` high in cycle t+1+`WAIT_CYCLES`.
- Minimum issue interval is `WAIT_CYCLES` + 2 cycles per transaction, because of the mandatory IDLE cycle between transactions.
- `data_ack`, `data_err` and `data_rd_data` are all registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro: `KRONOS_DMEM_RANGE_CHECK_EN`.
- Defined: the range check above is active and `data_err` reports faults.
- Undefined: no range comparator is built and `data_err` is tied to 0. The index is `addr[$clog2(DEPTH)+1:2]`, so addresses alias modulo `4*DEPTH`.

## Structure
- Add to the shared `kronos_types` package:
  - `dbus_req_t` packed struct {addr[31:0], wdata[31:0], mask[3:0], wr_en} for the captured request.
  - `dmem_state_e` enum {DMEM_IDLE, DMEM_WAIT, DMEM_RESP}.
- Sub-module `kronos_spsram`: single-port synchronous RAM with per-byte write enables and a registered read port. The responder instantiates it once.

## Test plan
- Reset: drive `rstz` = 0 with `data_req` = 1 → `data_ack`, `data_err` and `data_rd_data` all read 0. After release, the first ack arrives at cycle t+1.
- Word store then load, `WAIT_CYCLES` = 0:
  - Store 32'hDEADBEEF, mask 4'hF at `BASE_ADDR` + 8 → ack 1 cycle after req, `data_err` = 0.
  - Load from the same address → `data_rd_data` = 32'hDEADBEEF.
- Byte lanes: pre-load 32'h11223344, then store 32'hAA00_0000 with mask 4'b1000 → a subsequent load returns 32'hAA223344. A store with mask 4'b0000 leaves the word unchanged.
- Wait states: with `WAIT_CYCLES` = 3, req at edge t → ack exactly at cycle t+4. Changing `data_addr` during WAIT does not change the accessed word.
- Range fault (macro defined, `DEPTH` = 1024, `BASE_ADDR` = 0):
  - Store at 32'h1000 → ack with `data_err` = 1 and no write.
  - Load at 32'h0FFC → `data_err` = 0.
- Back-to-back: `data_req` held high for two loads → two ack pulses separated by one idle cycle. Asserting `rstz` = 0 during WAIT of a store → the target word is not modified.
